// File: rtl/mig_eval_sequencer.sv
// Majority-inverter-graph evaluator: time-shares one MAJ3 unit across a programmed
// node list, sweeping all 128 minterms of a 7-input function into a truth table.
module mig_eval_sequencer #(
  parameter int unsigned NUM_NODES = 8,
  parameter int unsigned SELW      = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prog_we,
  input  logic [4:0]   prog_addr,
  input  logic [17:0]  prog_data,
  input  logic [4:0]   node_count,
  input  logic         out_inv,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         tt_valid,
  output logic [127:0] tt_out
);

  localparam int unsigned OPW     = SELW + 1;
  localparam int unsigned ENTRY_W = 3 * OPW;
  localparam int unsigned SRC_W   = 1 << SELW;
  localparam int unsigned RES_W   = SRC_W - 8;
  localparam int unsigned AW      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int unsigned DEPTH   = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ENTRY_W-1:0] prog_mem [DEPTH];

  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       k_q, k_d;
  logic [6:0]       m_q, m_d;
  logic             inv_q, inv_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tt_valid_q, tt_valid_d;
  logic [127:0]     tt_out_q, tt_out_d;

  logic [ENTRY_W-1:0] entry_c;
  logic [SRC_W-1:0]   src_c;
  logic [SELW-1:0]    sel_c [3];
  logic [2:0]         opv_c;
  logic [2:0]         opbad_c;
  logic               node_val_c;
  logic               op_err_c;
  logic               last_node_c;
  logic               bad_count_c;

  // Program store has no reset; writes only land while idle and in range.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE) && (32'(prog_addr) < NUM_NODES)) begin
      prog_mem[prog_addr[AW-1:0]] <= prog_data;
    end
  end

  // Operand source vector: {node results, x6..x0, constant 0}, indexed by sel.
  always_comb begin
    entry_c = prog_mem[k_q[AW-1:0]];
    src_c   = {res_q, m_q, 1'b0};
    for (int i = 0; i < 3; i++) begin
      sel_c[i]   = entry_c[i*OPW +: SELW];
      opv_c[i]   = src_c[sel_c[i]] ^ entry_c[i*OPW + SELW];
      opbad_c[i] = (sel_c[i] >= SELW'(8)) && ((sel_c[i] - SELW'(8)) >= SELW'(k_q));
    end
    node_val_c  = (opv_c[0] & opv_c[1]) | (opv_c[0] & opv_c[2]) | (opv_c[1] & opv_c[2]);
    op_err_c    = |opbad_c;
    last_node_c = (k_q == (cnt_q - 5'd1));
    bad_count_c = (node_count == 5'd0) || (32'(node_count) > NUM_NODES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = bad_count_c ? FIN : EVAL;
        end
      end
      EVAL: begin
        if (op_err_c || (last_node_c && (m_q == 7'd127))) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    m_d        = m_q;
    k_d        = k_q;
    res_d      = res_q;
    tt_out_d   = tt_out_q;
    err_d      = err_q;
    tt_valid_d = tt_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = node_count;
          inv_d      = out_inv;
          m_d        = '0;
          k_d        = '0;
          tt_valid_d = 1'b0;
          err_d      = bad_count_c;
        end
      end
      EVAL: begin
        if (op_err_c) begin
          err_d = 1'b1;
        end else begin
          res_d[k_q] = node_val_c;
          if (last_node_c) begin
            tt_out_d[m_q] = node_val_c ^ inv_q;
            k_d           = '0;
            if (m_q != 7'd127) begin
              m_d = m_q + 7'd1;
            end
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
    // Status flags line up with the cycle the FSM spends in FIN.
    busy_d = (state_d == EVAL);
    done_d = (state_d == FIN);
    if (state_d == FIN) begin
      tt_valid_d = ~err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      m_q        <= '0;
      k_q        <= '0;
      res_q      <= '0;
      tt_out_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tt_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      m_q        <= m_d;
      k_q        <= k_d;
      res_q      <= res_d;
      tt_out_q   <= tt_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tt_valid_q <= tt_valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tt_valid = tt_valid_q;
  assign tt_out   = tt_out_q;

endmodule

// File: doc/mig_eval_sequencer.md
Name: mig_eval_sequencer

Overview:
Programmable majority-inverter-graph evaluator that time-shares one 3-input majority unit across up to NUM_NODES programmed nodes. It sweeps all 128 minterms of a 7-input function and accumulates the function's 128-bit truth table. It lets the classification flow check candidate MAJ netlists against target truth tables in hardware, without a separate fixed module per function.

Parameters:
NUM_NODES, 8, maximum number of majority nodes in the program store (1..24)
SELW, 5, operand selector width; fixed at 5 for NUM_NODES up to 24

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
prog_we  input  1  write strobe for the node program store
prog_addr  input  5  node index to write; must be < NUM_NODES
prog_data  input  18  node entry: [5:0] operand a, [11:6] operand b, [17:12] operand c; each operand is {inv, sel[4:0]}
node_count  input  5  number of active nodes; sampled on start
out_inv  input  1  complement of the final node output; sampled on start
start  input  1  single-cycle request to begin a sweep
busy  output  1  high while a sweep is running
done  output  1  one-cycle pulse when a sweep ends, normally or by abort
err  output  1  error status of the last sweep; valid from the done pulse until the next accepted start
tt_valid  output  1  tt_out holds a complete truth table
tt_out  output  128  truth table; bit m is f(x6..x0 = m)

Behaviour:
- Reset: busy=0, done=0, err=0, tt_valid=0, tt_out=0, FSM in IDLE. The program store is not reset and holds unknown contents until written. Reset during a sweep aborts it immediately.
- Operand decode:
  - sel 0: constant 0.
  - sel 1..7: x0..x6, taken from minterm bits m[0]..m[6].
  - sel 8+j: result of node j for the current minterm.
  - Any other sel value is illegal.
  - The operand value is the decoded value XOR inv.
- Node value = MAJ(a,b,c) = ab | ac | bc.
- Program writes:
  - Accepted only in IDLE; prog_addr >= NUM_NODES is ignored.
  - A write takes effect on the next cycle.
  - prog_we while busy is ignored.
- FSM states: IDLE, EVAL, FIN.
  - IDLE:
    - On start: latch node_count and out_inv, clear tt_valid and err.
    - If node_count is 0 or > NUM_NODES: go to FIN with err=1.
    - Otherwise go to EVAL with m=0, k=0, busy=1.
  - EVAL: exactly one node evaluated per cycle; result written to node-result register k.
    - If any operand of node k selects node j with j >= k, or uses an illegal sel: set err=1 and go to FIN. No further tt_out bits are written.
    - Else if k = node_count-1: tt_out[m] <= result ^ out_inv.
      - If m=127: go to FIN.
      - Otherwise m++ and k=0.
    - Else k++.
  - FIN:
    - done=1 for one cycle and busy=0.
    - tt_valid=1 only if err=0.
    - Return to IDLE.
- Latency from the start cycle to the done pulse is 128*node_count + 1 cycles.
- start while busy or in FIN is ignored.
- On abort, tt_out keeps the partially written bits and tt_valid stays 0.
- m is 7 bits and does not wrap; the sweep ends at 127.

Test Plan:
- Program 6 nodes: n0=MAJ(x0,x1,x3); n1=MAJ(x0,x4,n0); n2=MAJ(x0,x1,x6); n3=MAJ(x1,x3,x4); n4=MAJ(x5,n2,n3); n5=MAJ(x2,n1,n4). Set node_count=6, out_inv=0, start -> done 769 cycles after start, err=0, tt_valid=1, tt_out=128'hfeeaeae8eee8e880fee8e888e8a8a880.
- Same program with out_inv=1 -> tt_out = bitwise inverse of 128'hfeeaeae8eee8e880fee8e888e8a8a880.
- Single node n0=MAJ(x0,x1,~0), node_count=1 -> done after 129 cycles, tt_out=128'heeee_eeee_eeee_eeee_eeee_eeee_eeee_eeee.
- Error paths:
  - Node 1 references n2 (forward reference), node_count=3 -> abort on the first minterm, done with err=1, tt_valid=0.
  - node_count=0 -> done on the next cycle with err=1.
- Pulse start and prog_we mid-sweep -> both ignored; the result equals the undisturbed run.
- Assert rst_n=0 at cycle 300 of a sweep -> outputs return to reset values asynchronously. After release, a fresh start completes correctly.
